decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DEPTH, default 4, output queue entries; power of two, minimum 2.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch word offered.
REQ-006 in_ready  output  1  stage accepts fetch word this cycle.
REQ-007 in_inst  input  32  raw instruction word.
REQ-008 in_pc  input  PC_W  address of in_inst.
REQ-009 flush  input  1  discard all queued and pending work.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 out_en  output  EncodingType  one-hot format (R/I/S/B/U/J) of head.
REQ-013 out_op  output  InstructionSet  one-hot operation of head.
REQ-014 out_illegal  output  1  head is an illegal instruction.
REQ-015 out_inst, out_pc  output  32, PC_W  raw word and PC of head.
REQ-016 level  output  $clog2(DEPTH)+1  queued entry count.

Function
REQ-017 Transfer in: in_valid && in_ready at a rising edge; transfer out: out_valid && out_ready.
REQ-018 in_ready = (level != DEPTH) && state == RUN && !flush; no dependence on out_ready, no combinational in->out path.
REQ-019 Decode is combinational on in_inst, result registered into queue tail; latency accept -> out_valid = 1 cycle with empty queue.
REQ-020 Decode rules: full RV32I base set, FENCE/FENCE.TSO/PAUSE/ECALL/EBREAK; non-11 low bits, unknown opcode/funct3/funct7 -> en=0, op=0, illegal=1.
REQ-021 Queue FIFO-ordered; head outputs stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop when 0 < level < DEPTH: level unchanged, both pointers advance.
REQ-023 Pop at level==DEPTH frees a slot; in_ready rises the following cycle only.
REQ-024 Pointers log2(DEPTH) bits, wrap modulo DEPTH.
REQ-025 States RUN, TRAP; RUN -> TRAP when an entry with illegal=1 is pushed; TRAP -> RUN only on flush.
REQ-026 In TRAP, in_ready=0; queued entries (including the illegal one) still drain normally.
REQ-027 flush: next edge level=0, pointers=0, state=RUN; flush overrides push and pop in same cycle; out_valid=0 the cycle after.
REQ-028 out_valid = (level != 0); out_* contents undefined-but-stable when out_valid=0 (drive zero).

Reset
REQ-029 On rst_n low: level=0, pointers=0, state=RUN, out_valid=0, in_ready=0 while asserted, queue payload need not be cleared.
REQ-030 Reset mid-transfer drops all entries; first accept possible on first edge after rst_n deasserts.

Configuration
REQ-031 Macro DECODE_RV32M_EN: defined -> opcode 01100 with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (en.R); undefined -> those encodings illegal, InstructionSet fields for M ops absent.

Structure
REQ-032 EncodingType, InstructionSet, opcode constants, state enum in shared package instr_pkg.
REQ-033 Combinational decoder is sub-module inst_decode (inst -> en, op, illegal); decode_stage holds queue, FSM, handshake.

Verification
REQ-034 Empty queue, push ADDI x1,x0,5 (0x00500093, pc 0x100) -> next cycle out_valid=1, en.I=1, op.ADDI=1, out_pc=0x100.
REQ-035 DEPTH=4, out_ready=0, push 5 words back-to-back -> 4 accepted, level=4, in_ready=0; then out_ready=1 -> outputs in order, in_ready=1 one cycle after first pop.
REQ-036 Push 0x00000013 then 0x00000000 -> second entry illegal=1, in_ready=0 thereafter; both drain; flush -> state RUN, in_ready=1.
REQ-037 Push MUL x1,x2,x3 (0x023100B3) -> op.MUL=1 with DECODE_RV32M_EN, illegal=1 without.
REQ-038 level=3, flush with in_valid=1 and out_ready=1 same cycle -> level=0, nothing enqueued, out_valid=0 next cycle.
REQ-039 rst_n low mid-stream with level=2 -> immediately level=0, out_valid=0; after release accept resumes at pointer 0.

Source files
------------

// File: rtl/instr_pkg.sv
// instr_pkg: shared RV32I decode types (one-hot format and operation), opcodes, stage states.
// Build option DECODE_RV32M_EN adds the RV32M operation fields to InstructionSet.
package instr_pkg;

    typedef struct packed {
        logic R, I, S, B, U, J;
    } EncodingType;

    typedef struct packed {
        logic LUI, AUIPC, JAL, JALR;
        logic BEQ, BNE, BLT, BGE, BLTU, BGEU;
        logic LB, LH, LW, LBU, LHU;
        logic SB, SH, SW;
        logic ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
        logic ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
        logic FENCE, FENCE_TSO, PAUSE, ECALL, EBREAK;
`ifdef DECODE_RV32M_EN
        logic MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
`endif
    } InstructionSet;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_FENCE_TSO = 32'h8330_000F;
    localparam logic [31:0] INST_PAUSE     = 32'h0100_000F;
    localparam logic [31:0] INST_ECALL     = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK    = 32'h0010_0073;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } stage_state_e;

endpackage

// File: rtl/inst_decode.sv
// inst_decode: purely combinational RV32I decoder; any word that matches no operation is illegal.
// RV32M multiply/divide encodings decode only when DECODE_RV32M_EN is defined.
module inst_decode
    import instr_pkg::*;
(
    input  logic [31:0]   inst,
    output EncodingType   en,
    output InstructionSet op,
    output logic          illegal
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        en = '0;
        op = '0;
        // Opcode constants all end in 2'b11, so compressed-space words fall to default.
        case (inst[6:0])
            OPC_LUI:   begin en.U = 1'b1; op.LUI   = 1'b1; end
            OPC_AUIPC: begin en.U = 1'b1; op.AUIPC = 1'b1; end
            OPC_JAL:   begin en.J = 1'b1; op.JAL   = 1'b1; end
            OPC_JALR:  begin en.I = (funct3 == 3'b000); op.JALR = (funct3 == 3'b000); end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  op.BEQ  = 1'b1;
                    3'b001:  op.BNE  = 1'b1;
                    3'b100:  op.BLT  = 1'b1;
                    3'b101:  op.BGE  = 1'b1;
                    3'b110:  op.BLTU = 1'b1;
                    3'b111:  op.BGEU = 1'b1;
                    default: ;
                endcase
                en.B = (op != '0);
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000:  op.LB  = 1'b1;
                    3'b001:  op.LH  = 1'b1;
                    3'b010:  op.LW  = 1'b1;
                    3'b100:  op.LBU = 1'b1;
                    3'b101:  op.LHU = 1'b1;
                    default: ;
                endcase
                en.I = (op != '0);
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000:  op.SB = 1'b1;
                    3'b001:  op.SH = 1'b1;
                    3'b010:  op.SW = 1'b1;
                    default: ;
                endcase
                en.S = (op != '0);
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000:  op.ADDI  = 1'b1;
                    3'b010:  op.SLTI  = 1'b1;
                    3'b011:  op.SLTIU = 1'b1;
                    3'b100:  op.XORI  = 1'b1;
                    3'b110:  op.ORI   = 1'b1;
                    3'b111:  op.ANDI  = 1'b1;
                    3'b001:  op.SLLI  = (funct7 == F7_BASE);
                    3'b101: begin
                        op.SRLI = (funct7 == F7_BASE);
                        op.SRAI = (funct7 == F7_ALT);
                    end
                    default: ;
                endcase
                en.I = (op != '0);
            end
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  op.ADD  = 1'b1;
                            3'b001:  op.SLL  = 1'b1;
                            3'b010:  op.SLT  = 1'b1;
                            3'b011:  op.SLTU = 1'b1;
                            3'b100:  op.XOR  = 1'b1;
                            3'b101:  op.SRL  = 1'b1;
                            3'b110:  op.OR   = 1'b1;
                            default: op.AND  = 1'b1;
                        endcase
                    end
                    F7_ALT: begin
                        op.SUB = (funct3 == 3'b000);
                        op.SRA = (funct3 == 3'b101);
                    end
`ifdef DECODE_RV32M_EN
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  op.MUL    = 1'b1;
                            3'b001:  op.MULH   = 1'b1;
                            3'b010:  op.MULHSU = 1'b1;
                            3'b011:  op.MULHU  = 1'b1;
                            3'b100:  op.DIV    = 1'b1;
                            3'b101:  op.DIVU   = 1'b1;
                            3'b110:  op.REM    = 1'b1;
                            default: op.REMU   = 1'b1;
                        endcase
                    end
`endif
                    default: ;
                endcase
                en.R = (op != '0);
            end
            OPC_MISC_MEM: begin
                if (funct3 == 3'b000) begin
                    en.I = 1'b1;
                    if (inst == INST_FENCE_TSO)  op.FENCE_TSO = 1'b1;
                    else if (inst == INST_PAUSE) op.PAUSE     = 1'b1;
                    else                         op.FENCE     = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                op.ECALL  = (inst == INST_ECALL);
                op.EBREAK = (inst == INST_EBREAK);
                en.I      = (op != '0);
            end
            default: ;
        endcase
    end

    assign illegal = (op == '0);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes accepted fetch words into a DEPTH-entry FIFO; RUN/TRAP FSM stalls after an illegal push.
// Build option DECODE_RV32M_EN (passed to inst_decode) enables RV32M decoding.
module decode_stage
    import instr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output EncodingType              out_en,
    output InstructionSet            out_op,
    output logic                     out_illegal,
    output logic [31:0]              out_inst,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        EncodingType     en;
        InstructionSet   op;
        logic            illegal;
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } entry_t;

    EncodingType   dec_en;
    InstructionSet dec_op;
    logic          dec_illegal;

    inst_decode u_dec (
        .inst    (in_inst),
        .en      (dec_en),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    entry_t              mem_q [DEPTH];
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    stage_state_e        state_q, state_d;
    logic                push, pop;

    // Gating with rst_n keeps the stage from advertising space while reset is held.
    assign in_ready  = rst_n && (level_q != LVL_W'(DEPTH)) && (state_q == RUN) && !flush;
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        state_d  = state_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            state_d  = RUN;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: ;
            endcase
            if (push && dec_illegal) state_d = TRAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
        end
    end

    // NOTE: payload storage has no reset; level_q alone decides which slots hold valid data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{en: dec_en, op: dec_op, illegal: dec_illegal,
                                 inst: in_inst, pc: in_pc};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_en      = out_valid ? head.en      : '0;
    assign out_op      = out_valid ? head.op      : '0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
    assign out_inst    = out_valid ? head.inst    : '0;
    assign out_pc      = out_valid ? head.pc      : '0;
    assign level       = level_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: decode vector table, directed queue/trap/flush/reset sequences, and randomized
// traffic checked against a mask/match instruction table plus a queue-based stage model.
module tb_decode_stage;
    import instr_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0]      in_inst, out_inst;
    logic [PC_W-1:0]  in_pc, out_pc;
    EncodingType      out_en;
    InstructionSet    out_op;
    logic [LVL_W-1:0] level;
    int               total, bad;

    decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_en(out_en), .out_op(out_op),
        .out_illegal(out_illegal), .out_inst(out_inst), .out_pc(out_pc), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   mask;
        logic [31:0]   match;
        EncodingType   en;
        InstructionSet op;
    } rule_t;

    typedef struct packed {
        logic [31:0]   inst;
        EncodingType   en;
        InstructionSet op;
        logic          ill;
    } vec_t;

    typedef struct packed {
        vec_t            d;
        logic [PC_W-1:0] pc;
    } ment_t;

    rule_t rules[$];
    vec_t  vecs[$];
    ment_t mq[$];
    bit    mtrap;

`define RULE(MASK, MATCH, ENF, OPF) begin rule_t r; r = '0; r.mask = MASK; r.match = MATCH; r.en.ENF = 1'b1; r.op.OPF = 1'b1; rules.push_back(r); end
`define VEC(INST, ENF, OPF) begin vec_t v; v = '0; v.inst = INST; v.en.ENF = 1'b1; v.op.OPF = 1'b1; vecs.push_back(v); end
`define VIL(INST) begin vec_t v; v = '0; v.inst = INST; v.ill = 1'b1; vecs.push_back(v); end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_head(input string tag, input vec_t e, input logic [PC_W-1:0] pc);
        check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, ".en"}, 64'(out_en), 64'(e.en));
        check({tag, ".op"}, 64'(out_op), 64'(e.op));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(e.ill));
        check({tag, ".inst"}, 64'(out_inst), 64'(e.inst));
        check({tag, ".pc"}, 64'(out_pc), 64'(pc));
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // First matching mask/match rule wins; exact-word rules precede the generic FENCE rule.
    function automatic vec_t ref_decode(input logic [31:0] w);
        vec_t v;
        bit   found;
        v = '0; v.inst = w; v.ill = 1'b1; found = 1'b0;
        foreach (rules[k]) begin
            if (!found && ((w & rules[k].mask) == rules[k].match)) begin
                found = 1'b1; v.en = rules[k].en; v.op = rules[k].op; v.ill = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] gen_word();
        rule_t       r;
        logic [31:0] w;
        r = rules[$urandom_range(0, rules.size() - 1)];
        w = r.match | ($urandom() & ~r.mask);
        if ($urandom_range(0, 3) == 0) w = w ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) w = $urandom();
        return w;
    endfunction

    task automatic build_tables();
        `RULE(32'hFFFFFFFF, 32'h8330000F, I, FENCE_TSO)
        `RULE(32'hFFFFFFFF, 32'h0100000F, I, PAUSE)
        `RULE(32'hFFFFFFFF, 32'h00000073, I, ECALL)
        `RULE(32'hFFFFFFFF, 32'h00100073, I, EBREAK)
        `RULE(32'h0000707F, 32'h0000000F, I, FENCE)
        `RULE(32'h0000007F, 32'h00000037, U, LUI)
        `RULE(32'h0000007F, 32'h00000017, U, AUIPC)
        `RULE(32'h0000007F, 32'h0000006F, J, JAL)
        `RULE(32'h0000707F, 32'h00000067, I, JALR)
        `RULE(32'h0000707F, 32'h00000063, B, BEQ)
        `RULE(32'h0000707F, 32'h00001063, B, BNE)
        `RULE(32'h0000707F, 32'h00004063, B, BLT)
        `RULE(32'h0000707F, 32'h00005063, B, BGE)
        `RULE(32'h0000707F, 32'h00006063, B, BLTU)
        `RULE(32'h0000707F, 32'h00007063, B, BGEU)
        `RULE(32'h0000707F, 32'h00000003, I, LB)
        `RULE(32'h0000707F, 32'h00001003, I, LH)
        `RULE(32'h0000707F, 32'h00002003, I, LW)
        `RULE(32'h0000707F, 32'h00004003, I, LBU)
        `RULE(32'h0000707F, 32'h00005003, I, LHU)
        `RULE(32'h0000707F, 32'h00000023, S, SB)
        `RULE(32'h0000707F, 32'h00001023, S, SH)
        `RULE(32'h0000707F, 32'h00002023, S, SW)
        `RULE(32'h0000707F, 32'h00000013, I, ADDI)
        `RULE(32'h0000707F, 32'h00002013, I, SLTI)
        `RULE(32'h0000707F, 32'h00003013, I, SLTIU)
        `RULE(32'h0000707F, 32'h00004013, I, XORI)
        `RULE(32'h0000707F, 32'h00006013, I, ORI)
        `RULE(32'h0000707F, 32'h00007013, I, ANDI)
        `RULE(32'hFE00707F, 32'h00001013, I, SLLI)
        `RULE(32'hFE00707F, 32'h00005013, I, SRLI)
        `RULE(32'hFE00707F, 32'h40005013, I, SRAI)
        `RULE(32'hFE00707F, 32'h00000033, R, ADD)
        `RULE(32'hFE00707F, 32'h40000033, R, SUB)
        `RULE(32'hFE00707F, 32'h00001033, R, SLL)
        `RULE(32'hFE00707F, 32'h00002033, R, SLT)
        `RULE(32'hFE00707F, 32'h00003033, R, SLTU)
        `RULE(32'hFE00707F, 32'h00004033, R, XOR)
        `RULE(32'hFE00707F, 32'h00005033, R, SRL)
        `RULE(32'hFE00707F, 32'h40005033, R, SRA)
        `RULE(32'hFE00707F, 32'h00006033, R, OR)
        `RULE(32'hFE00707F, 32'h00007033, R, AND)
`ifdef DECODE_RV32M_EN
        `RULE(32'hFE00707F, 32'h02000033, R, MUL)
        `RULE(32'hFE00707F, 32'h02001033, R, MULH)
        `RULE(32'hFE00707F, 32'h02002033, R, MULHSU)
        `RULE(32'hFE00707F, 32'h02003033, R, MULHU)
        `RULE(32'hFE00707F, 32'h02004033, R, DIV)
        `RULE(32'hFE00707F, 32'h02005033, R, DIVU)
        `RULE(32'hFE00707F, 32'h02006033, R, REM)
        `RULE(32'hFE00707F, 32'h02007033, R, REMU)
`endif
        `VEC(32'h00500093, I, ADDI)
        `VEC(32'h40208033, R, SUB)
        `VEC(32'h000122B7, U, LUI)
        `VEC(32'h00000017, U, AUIPC)
        `VEC(32'h0000006F, J, JAL)
        `VEC(32'h00208463, B, BEQ)
        `VEC(32'h0020A423, S, SW)
        `VEC(32'h0000C083, I, LBU)
        `VEC(32'h4010D093, I, SRAI)
        `VEC(32'h0FF0000F, I, FENCE)
        `VEC(32'h8330000F, I, FENCE_TSO)
        `VEC(32'h0100000F, I, PAUSE)
        `VEC(32'h00000073, I, ECALL)
        `VEC(32'h00100073, I, EBREAK)
`ifdef DECODE_RV32M_EN
        `VEC(32'h023100B3, R, MUL)
`else
        `VIL(32'h023100B3)
`endif
        `VIL(32'h00000000)
        `VIL(32'h00500092)
        `VIL(32'h0000100F)
        `VIL(32'h00003083)
        `VIL(32'h02009093)
        `VIL(32'h00200073)
        `VIL(32'h00001073)
        `VIL(32'h80000033)
    endtask

    initial begin
        logic [31:0] w;
        bit          exp_rdy, do_push, do_pop;
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        build_tables();

        #2;
        check("rst.level", 64'(level), 64'(0));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst.release_ready", 64'(in_ready), 64'(1));

        // Single-entry decode: accept, then head visible one cycle later.
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 32'h100 + 32'(i) * 4; out_ready = 1'b0;
            #1 check("tbl.in_ready", 64'(in_ready), 64'(1));
            cyc();
            in_valid = 1'b0;
            #1 check_head($sformatf("tbl[%0d]", i), vecs[i], 32'h100 + 32'(i) * 4);
            flush = 1'b1;
            cyc();
            flush = 1'b0;
            #1 check("tbl.flushed", 64'(out_valid), 64'(0));
        end

        // Back-pressure: five offered, four accepted, in_ready returns one cycle after the pop.
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1; in_inst = 32'h00000093 | (32'(j + 1) << 20); in_pc = 32'h200 + 32'(j) * 4;
            #1 check($sformatf("full.in_ready%0d", j), 64'(in_ready), 64'(j < 4));
            cyc();
        end
        in_valid = 1'b0;
        #1 check("full.level", 64'(level), 64'(4));
        check_head("full.head0", ref_decode(32'h00100093), 32'h200);
        out_ready = 1'b1;
        #1 check("full.ready_pop_cycle", 64'(in_ready), 64'(0));
        cyc();
        #1 check("full.ready_after_pop", 64'(in_ready), 64'(1));
        for (int j = 1; j < 4; j++) begin
            check_head($sformatf("full.head%0d", j), ref_decode(32'h00000093 | (32'(j + 1) << 20)),
                       32'h200 + 32'(j) * 4);
            cyc();
        end
        #1 check("full.drained", 64'(out_valid), 64'(0));

        // Illegal push enters TRAP; queued entries still drain; only flush resumes.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h500;
        cyc();
        in_inst = 32'h00000000; in_pc = 32'h504;
        cyc();
        in_inst = 32'h00000013;
        #1 check("trap.in_ready", 64'(in_ready), 64'(0));
        check("trap.level", 64'(level), 64'(2));
        out_ready = 1'b1;
        check("trap.head0_ill", 64'(out_illegal), 64'(0));
        cyc();
        #1 check("trap.head1_ill", 64'(out_illegal), 64'(1));
        check("trap.head1_inst", 64'(out_inst), 64'(0));
        cyc();
        #1 check("trap.drained", 64'(level), 64'(0));
        check("trap.still_blocked", 64'(in_ready), 64'(0));
        cyc();
        #1 check("trap.no_enqueue", 64'(level), 64'(0));
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1 check("trap.resume_ready", 64'(in_ready), 64'(1));

        // Flush overrides a same-cycle push and pop.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013;
        repeat (3) cyc();
        #1 check("flush.level3", 64'(level), 64'(3));
        flush = 1'b1; out_ready = 1'b1;
        #1 check("flush.in_ready", 64'(in_ready), 64'(0));
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1 check("flush.level", 64'(level), 64'(0));
        check("flush.out_valid", 64'(out_valid), 64'(0));
        cyc();
        #1 check("flush.nothing_enqueued", 64'(level), 64'(0));

        // Asynchronous reset mid-stream.
        in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h300;
        cyc();
        in_pc = 32'h304;
        cyc();
        in_valid = 1'b0;
        #1 check("arst.level2", 64'(level), 64'(2));
        rst_n = 1'b0;
        #1 check("arst.level", 64'(level), 64'(0));
        check("arst.out_valid", 64'(out_valid), 64'(0));
        check("arst.in_ready", 64'(in_ready), 64'(0));
        cyc();
        rst_n = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h400;
        #1 check("arst.ready", 64'(in_ready), 64'(1));
        cyc();
        in_valid = 1'b0;
        #1 check_head("arst.head", ref_decode(32'h00500093), 32'h400);
        check("arst.level1", 64'(level), 64'(1));
        flush = 1'b1;
        cyc();
        flush = 1'b0;

        // Randomized traffic against the stage model.
        mq.delete(); mtrap = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            w = gen_word();
            in_valid = ($urandom_range(0, 3) != 0); in_inst = w; in_pc = $urandom();
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 59) == 0) || (mtrap && mq.size() == 0 && $urandom_range(0, 3) == 0);
            #1;
            exp_rdy = (mq.size() < DEPTH) && !mtrap && !flush;
            check("rnd.in_ready", 64'(in_ready), 64'(exp_rdy));
            check("rnd.level", 64'(level), 64'(mq.size()));
            if (mq.size() != 0) begin
                check_head("rnd.head", mq[0].d, mq[0].pc);
            end else begin
                check("rnd.out_valid", 64'(out_valid), 64'(0));
                check("rnd.idle_inst", 64'(out_inst), 64'(0));
                check("rnd.idle_op", 64'(out_op), 64'(0));
            end
            do_push = in_valid && exp_rdy;
            do_pop  = (mq.size() != 0) && out_ready;
            @(posedge clk);
            if (flush) begin
                mq.delete();
                mtrap = 1'b0;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    ment_t m;
                    m.d  = ref_decode(w);
                    m.pc = in_pc;
                    mq.push_back(m);
                    if (m.d.ill) mtrap = 1'b1;
                end
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
